// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with one write port and one read port, plus per-byte write enables.
// Reads are registered, the read-during-write policy is selectable, and an optional zeroing sweep runs after reset.
module ram_sdp_be #(
  parameter int addr_size      = 10,
  parameter int word_size      = 32,
  parameter int memory_size    = 1024,
  parameter int rdw_mode       = 0,
  parameter int clear_on_reset = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [addr_size-1:0]   wr_addr,
  input  logic [word_size-1:0]   data_in,
  input  logic [word_size/8-1:0] wr_be,
  input  logic                   rd,
  input  logic [addr_size-1:0]   rd_addr,
  output logic [word_size-1:0]   data_out,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   addr_err
);
  // Handshake: wr/rd are single-cycle requests sampled on every rising edge while busy=0.
  // There is no ready/stall. A read result appears with rd_valid=1 exactly one cycle later.

  localparam int lanes = word_size / 8;
  localparam int idx_w = (memory_size > 1) ? $clog2(memory_size) : 1;
  localparam logic [addr_size:0]   lim      = (addr_size + 1)'(memory_size);
  localparam logic [addr_size-1:0] last_ptr = addr_size'(memory_size - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                 state;
  logic [addr_size-1:0]   ptr;
  logic [word_size-1:0]   mem [memory_size];

  logic                   wr_in;
  logic                   rd_in;
  logic                   ready;
  logic                   wr_go;
  logic                   clear_go;
  logic                   collide;
  logic [idx_w-1:0]       wr_idx;
  logic [idx_w-1:0]       rd_idx;
  logic [idx_w-1:0]       ptr_idx;
  logic [word_size-1:0]   rd_old;
  logic [word_size-1:0]   rd_merged;

  assign wr_in    = {1'b0, wr_addr} < lim;
  assign rd_in    = {1'b0, rd_addr} < lim;
  assign ready    = (state == READY);
  assign busy     = (state == CLEAR);
  assign wr_go    = ready && !rst && wr && wr_in;
  assign clear_go = busy && !rst;
  assign collide  = wr_go && (wr_addr == rd_addr);
  assign wr_idx   = wr_addr[idx_w-1:0];
  assign rd_idx   = rd_addr[idx_w-1:0];
  assign ptr_idx  = ptr[idx_w-1:0];
  assign rd_old   = mem[rd_idx];

  // Write-through view of the read word: enabled lanes come from data_in, the rest from the array.
  always_comb begin
    rd_merged = rd_old;
    for (int i = 0; i < lanes; i++) begin
      if (wr_be[i]) rd_merged[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  // The storage array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (clear_go) begin
      mem[ptr_idx] <= '0;
    end else if (wr_go) begin
      for (int i = 0; i < lanes; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (clear_on_reset != 0) ? CLEAR : READY;
      ptr      <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          ptr      <= ptr + 1'b1;
          rd_valid <= 1'b0;
          addr_err <= 1'b0;
          if (ptr == last_ptr) state <= READY;
        end
        READY: begin
          rd_valid <= rd;
          addr_err <= (rd && !rd_in) || (wr && !wr_in);
          if (rd) begin
            if (!rd_in)                          data_out <= '0;
            else if (rdw_mode != 0 && collide)   data_out <= rd_merged;
            else                                 data_out <= rd_old;
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, one clock.
- Successor to the team's single-port asynchronous-read RAM. Adds:
  - a registered read with valid flag;
  - per-byte write enables;
  - a selectable read-during-write policy;
  - an optional post-reset clear sweep, driven by a small FSM.
- Used as the generic storage primitive under buffers and register files in the datapath.

Parameters:
- addr_size, 10, address width in bits.
- word_size, 32, data width in bits; must be a multiple of 8.
- memory_size, 1024, number of words; must satisfy 1 <= memory_size <= 2^addr_size.
- rdw_mode, 0, same-address read/write collision: 0 = return old data, 1 = return new (write-through) data.
- clear_on_reset, 1, 1 = zero every word after reset before accepting traffic; 0 = no sweep.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr  input  1  write request.
- wr_addr  input  addr_size  write address.
- data_in  input  word_size  write data.
- wr_be  input  word_size/8  byte enables; bit i enables data_in[8i+7:8i].
- rd  input  1  read request.
- rd_addr  input  addr_size  read address.
- data_out  output  word_size  registered read data.
- rd_valid  output  1  data_out holds the result of the read issued in the previous cycle.
- busy  output  1  clear sweep in progress; wr and rd are ignored.
- addr_err  output  1  one-cycle pulse: an accepted request in the previous cycle used an address >= memory_size.

Behaviour:
- Reset (rst=1, asynchronous):
  - data_out=0, rd_valid=0, addr_err=0.
  - FSM goes to CLEAR with the sweep pointer at 0 if clear_on_reset=1, otherwise to READY.
  - busy=1 during reset when clear_on_reset=1, else 0.
  - Memory array contents are not reset by rst itself.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes all-zeros to mem[ptr], then ptr increments. After writing ptr=memory_size-1, next state is READY. Sweep takes exactly memory_size cycles after rst deasserts.
  - READY: normal operation. Stays in READY until rst.
- busy=1 exactly while the FSM is in CLEAR.
- In CLEAR, wr and rd are ignored: no array write, rd_valid stays 0, addr_err stays 0. Requesters must hold their requests until busy=0.
- Write (READY, wr=1, wr_addr<memory_size):
  - at the clock edge, each byte lane with wr_be[i]=1 takes the data_in byte; other lanes are kept.
  - wr_be=0 is a legal no-op write.
- Read (READY, rd=1, rd_addr<memory_size):
  - next cycle, data_out=mem[rd_addr] and rd_valid=1. Latency is exactly 1 cycle.
- With rd=0, the next cycle has rd_valid=0 and data_out holds its last value.
- Out-of-range address (>= memory_size, only possible when memory_size<2^addr_size):
  - write is dropped;
  - read returns data_out=0 with rd_valid=1;
  - addr_err=1 the next cycle. A write error and a read error in the same cycle still give a single addr_err pulse.
- Collision (wr and rd same cycle, same in-range address):
  - rdw_mode=0: data_out = word before the write.
  - rdw_mode=1: data_out = merged result: enabled lanes from data_in, disabled lanes from the old word.
  - The array is updated in both modes.
- Reads and writes to different addresses in the same cycle are fully independent.
- Reset mid-sweep or mid-traffic:
  - the FSM restarts CLEAR from address 0 (if enabled);
  - any read issued in the reset cycle is lost (rd_valid=0);
  - partially swept words need no special handling, since the sweep rewrites all of them.
- Throughput: one read and one write every cycle in READY, with no bubbles.

Test Plan:
- Reset + clear (memory_size=16, clear_on_reset=1):
  - pulse rst, then count busy cycles → busy high for exactly 16 cycles after deassert.
  - read all addresses → data_out=0, rd_valid=1 one cycle after each rd.
- Byte-enable merge (word_size=32):
  - write 0xAABBCCDD to addr 5 with wr_be=4'hF, then 0x11223344 with wr_be=4'b0101;
  - read addr 5 → data_out=0xAA22CC44 one cycle later.
- Collision policy:
  - mem[3]=0x00000000; same cycle wr addr 3 data 0xDEADBEEF be=4'hF, rd addr 3;
  - rdw_mode=0 → data_out=0x00000000; rdw_mode=1 → data_out=0xDEADBEEF;
  - next read of addr 3 → 0xDEADBEEF in both modes.
- Out of range (addr_size=5, memory_size=20):
  - write 0x12345678 to addr 25 → addr_err=1 for one cycle, no array change.
  - read addr 25 → data_out=0, rd_valid=1, addr_err=1.
  - read addr 19 → unchanged contents.
- Requests during busy and mid-sweep reset:
  - issue wr addr 0 data 0xFFFFFFFF while busy=1 → ignored; read addr 0 after busy=0 returns 0.
  - assert rst at sweep address 7 → busy stays high for a full 16 cycles after the new deassert.
- Back-to-back streaming:
  - write addrs 0..15 with data=addr*0x01010101 on consecutive cycles, reading addr n-1 each cycle;
  - rd_valid continuously 1 and each data_out matches, no stalls.
